// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the LFSR random-word scheduler.
//   sched_state_e : scheduler FSM states (warm-up / serving)
//   lfsr_next     : one Fibonacci step, q -> {q[w-2:0], ^(q & taps)}
//   rr_pick       : round-robin one-hot pick starting at ptr
// Helpers work on MAX_*-wide vectors; callers cast to their own width.
package lfsr_pkg;

    localparam int unsigned MAX_WIDTH = 32;
    localparam int unsigned MAX_REQ   = 32;
    localparam int unsigned REQ_IW    = $clog2(MAX_REQ);

    typedef enum logic {
        ST_WARMUP,
        ST_SERVE
    } sched_state_e;

    function automatic logic [MAX_WIDTH-1:0] lfsr_next(
        input logic [MAX_WIDTH-1:0] q,
        input logic [MAX_WIDTH-1:0] taps,
        input int unsigned          width
    );
        logic                 fb;
        logic [MAX_WIDTH-1:0] mask;
        fb   = ^(q & taps);
        mask = {MAX_WIDTH{1'b1}} >> (MAX_WIDTH - width);
        return ((q << 1) | MAX_WIDTH'(fb)) & mask;
    endfunction

    // Search ptr, ptr+1, ... (mod n) and return the first set request as one-hot.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] req,
        input int unsigned        ptr,
        input int unsigned        n
    );
        logic [MAX_REQ-1:0] g;
        logic               found;
        logic [REQ_IW-1:0]  sel;
        g     = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            if (k < n && !found) begin
                sel = REQ_IW'((ptr + k) % n);
                if (req[sel]) begin
                    g[sel] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/lfsr_rand_sched_core.sv
// lfsr_core: Fibonacci LFSR register.
//   clk, rst  : clock, asynchronous active-high reset (q <= SEED)
//   step      : advance one LFSR step
//   load      : load load_val (takes priority over step)
//   load_val  : value to load; caller guarantees it is non-zero
//   q         : current LFSR state
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH = 5,
    parameter logic [WIDTH-1:0] TAPS  = 5'b10010,
    parameter logic [WIDTH-1:0] SEED  = 5'b00001
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_next;

    assign q_next = WIDTH'(lfsr_next(MAX_WIDTH'(q), MAX_WIDTH'(TAPS), WIDTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= SEED;
        end else if (load) begin
            q <= load_val;
        end else if (step) begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/lfsr_rand_sched.sv
// lfsr_rand_sched: shares one LFSR between NUM_REQ requesters, round-robin,
// one random word per cycle, with seeding, warm-up and zero-seed rejection.
//   clk, rst   : clock, asynchronous active-high reset
//   req        : per-requester request, held until granted
//   gnt        : registered one-hot grant pulse
//   rvalid     : random word valid, coincident with gnt
//   rdata      : random word (LFSR value before the granting step)
//   ready      : high while serving
//   seed_load  : load seed_val (priority over arbitration)
//   seed_val   : seed to load; zero is replaced by SEED
//   lockup_err : pulse when a zero seed was rejected
module lfsr_rand_sched
    import lfsr_pkg::*;
#(
    parameter int unsigned      NUM_REQ = 4,
    parameter int unsigned      WIDTH   = 5,
    parameter logic [WIDTH-1:0] TAPS    = 5'b10010,
    parameter logic [WIDTH-1:0] SEED    = 5'b00001,
    parameter int unsigned      WARMUP  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic               rvalid,
    output logic [WIDTH-1:0]   rdata,
    output logic               ready,
    input  logic               seed_load,
    input  logic [WIDTH-1:0]   seed_val,
    output logic               lockup_err
);

    localparam int unsigned PW = $clog2(NUM_REQ);
    localparam int unsigned CW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    localparam sched_state_e INIT_STATE = (WARMUP == 0) ? ST_SERVE : ST_WARMUP;

    sched_state_e       state;
    logic [CW-1:0]      cnt;
    logic [PW-1:0]      rr_ptr;
    logic [WIDTH-1:0]   q;
    logic [NUM_REQ-1:0] pick;
    logic [PW-1:0]      pick_idx;
    logic [PW-1:0]      ptr_next;
    logic               serve_hit;
    logic               core_step;
    logic               seed_zero;
    logic [WIDTH-1:0]   load_val;

    assign ready     = (state == ST_SERVE);
    assign seed_zero = (seed_val == '0);
    assign load_val  = seed_zero ? SEED : seed_val;
    assign serve_hit = !seed_load && (state == ST_SERVE) && (|req);
    assign core_step = !seed_load && ((state == ST_WARMUP) || serve_hit);

    assign pick = NUM_REQ'(rr_pick(MAX_REQ'(req), 32'(rr_ptr), NUM_REQ));

    always_comb begin
        pick_idx = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (pick[k]) begin
                pick_idx = PW'(k);
            end
        end
    end

    assign ptr_next = (pick_idx == PW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .step     (core_step),
        .load     (seed_load),
        .load_val (load_val),
        .q        (q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= INIT_STATE;
            cnt        <= CW'(WARMUP);
            rr_ptr     <= '0;
            gnt        <= '0;
            rvalid     <= 1'b0;
            rdata      <= '0;
            lockup_err <= 1'b0;
        end else begin
            gnt        <= '0;
            rvalid     <= 1'b0;
            lockup_err <= 1'b0;
            if (seed_load) begin
                lockup_err <= seed_zero;
                cnt        <= CW'(WARMUP);
                state      <= INIT_STATE;
            end else begin
                case (state)
                    ST_WARMUP: begin
                        cnt <= cnt - 1'b1;
                        if (cnt == CW'(1)) begin
                            state <= ST_SERVE;
                        end
                    end
                    ST_SERVE: begin
                        if (serve_hit) begin
                            gnt    <= pick;
                            rvalid <= 1'b1;
                            rdata  <= q;
                            rr_ptr <= ptr_next;
                        end
                    end
                    default: state <= INIT_STATE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lfsr_rand_sched.sv
module tb_lfsr_rand_sched;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       rvalid;
    logic [4:0] rdata;
    logic       ready;
    logic       seed_load;
    logic [4:0] seed_val;
    logic       lockup_err;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic [4:0] m_q;
    int         m_warm;
    int         m_ptr;
    logic [3:0] m_gnt;
    logic       m_rvalid;
    logic [4:0] m_rdata;
    logic       m_lerr;

    lfsr_rand_sched #(
        .NUM_REQ (4),
        .WIDTH   (5),
        .TAPS    (5'b10010),
        .SEED    (5'b00001),
        .WARMUP  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .gnt        (gnt),
        .rvalid     (rvalid),
        .rdata      (rdata),
        .ready      (ready),
        .seed_load  (seed_load),
        .seed_val   (seed_val),
        .lockup_err (lockup_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Parity of tapped bits via a population count.
    function automatic logic [4:0] nxt(input logic [4:0] v);
        int fb;
        fb = $countones(v & 5'b10010) % 2;
        return 5'(((int'(v) * 2) + fb) % 32);
    endfunction

    function automatic logic [12:0] expv();
        return {m_gnt, m_rvalid, m_rdata, (m_warm == 0), m_lerr};
    endfunction

    function automatic logic [12:0] actv();
        return {gnt, rvalid, rdata, ready, lockup_err};
    endfunction

    task automatic model_reset();
        m_q = 5'd1; m_warm = 4; m_ptr = 0;
        m_gnt = '0; m_rvalid = 1'b0; m_rdata = '0; m_lerr = 1'b0;
    endtask

    task automatic model_step();
        bit found;
        int idx;
        m_gnt = '0; m_rvalid = 1'b0; m_lerr = 1'b0;
        if (seed_load) begin
            m_q    = (seed_val != 0) ? seed_val : 5'd1;
            m_lerr = (seed_val == 0);
            m_warm = 4;
        end else if (m_warm > 0) begin
            m_q = nxt(m_q);
            m_warm--;
        end else if (req != 0) begin
            found = 0;
            for (int k = 0; k < 4; k++) begin
                idx = (m_ptr + k) % 4;
                if (!found && req[idx]) begin
                    found       = 1;
                    m_gnt[idx]  = 1'b1;
                    m_rvalid    = 1'b1;
                    m_rdata     = m_q;
                    m_q         = nxt(m_q);
                    m_ptr       = (idx + 1) % 4;
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req = '0; seed_load = 1'b0; seed_val = '0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; seed_load = 1'b0; seed_val = '0;
        #2;
        n_tests++;
        if ({gnt, rvalid, rdata, ready, lockup_err} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want %b", actv(), 13'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int c = 1; c <= 4; c++) begin
            tick();
            n_tests++;
            if (ready !== (c == 4)) begin
                n_fail++;
                $display("FAIL warmup_ready edge %0d: got %b want %b", c, ready, (c == 4));
            end
        end
        n_tests++;
        if (dut.q !== 5'b10101) begin
            n_fail++;
            $display("FAIL warmup_q: got %b want 10101", dut.q);
        end
    endtask

    task automatic test_single();
        logic [4:0] want [3];
        want[0] = 5'b10101; want[1] = 5'b01011; want[2] = 5'b10111;
        req = 4'b0001;
        for (int c = 0; c < 6; c++) begin
            tick();
            n_tests++;
            if (actv() !== expv()) begin
                n_fail++;
                $display("FAIL single cyc %0d: got %b want %b", c, actv(), expv());
            end
            if (c < 3) begin
                n_tests++;
                if (gnt !== 4'b0001 || rvalid !== 1'b1 || rdata !== want[c]) begin
                    n_fail++;
                    $display("FAIL single_const cyc %0d: gnt %b rv %b rdata %b want 0001 1 %b",
                             c, gnt, rvalid, rdata, want[c]);
                end
            end
        end
        req = '0;
        tick();
        n_tests++;
        if (gnt !== 4'b0000 || rvalid !== 1'b0 || rdata !== m_rdata) begin
            n_fail++;
            $display("FAIL idle_hold: gnt %b rv %b rdata %b want 0000 0 %b", gnt, rvalid, rdata, m_rdata);
        end
    endtask

    task automatic test_all_req();
        logic [3:0] want [5];
        want[0] = 4'b0001; want[1] = 4'b0010; want[2] = 4'b0100;
        want[3] = 4'b1000; want[4] = 4'b0001;
        do_reset();
        for (int c = 0; c < 4; c++) tick();
        req = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_tests++;
            if (gnt !== want[c] || actv() !== expv()) begin
                n_fail++;
                $display("FAIL rr_all cyc %0d: got %b want gnt %b vec %b", c, actv(), want[c], expv());
            end
        end
        req = '0;
    endtask

    task automatic test_lockup();
        req = 4'b0010; seed_load = 1'b1; seed_val = 5'd0;
        tick();
        seed_load = 1'b0; req = '0;
        n_tests++;
        if (gnt !== 4'b0000 || rvalid !== 1'b0 || lockup_err !== 1'b1 ||
            dut.q !== 5'b00001 || ready !== 1'b0) begin
            n_fail++;
            $display("FAIL lockup: gnt %b rv %b lerr %b q %b ready %b want 0000 0 1 00001 0",
                     gnt, rvalid, lockup_err, dut.q, ready);
        end
        for (int c = 1; c <= 4; c++) begin
            tick();
            n_tests++;
            if (actv() !== expv() || ready !== (c == 4)) begin
                n_fail++;
                $display("FAIL lockup_recover cyc %0d: got %b want %b", c, actv(), expv());
            end
        end
    endtask

    task automatic test_seed_warmup();
        int waited;
        do_reset();
        tick();
        tick();
        seed_load = 1'b1; seed_val = 5'($urandom_range(1, 31));
        tick();
        seed_load = 1'b0;
        n_tests++;
        if (dut.q !== m_q || lockup_err !== 1'b0 || ready !== 1'b0) begin
            n_fail++;
            $display("FAIL seed_in_warmup: q %b lerr %b ready %b want %b 0 0", dut.q, lockup_err, ready, m_q);
        end
        waited = 0;
        while (ready !== 1'b1 && waited < 10) begin
            tick();
            waited++;
        end
        n_tests++;
        if (waited != 4) begin
            n_fail++;
            $display("FAIL warmup_restart: ready after %0d cycles want 4", waited);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            req       = 4'($urandom_range(0, 15));
            seed_load = ($urandom_range(0, 19) == 0);
            seed_val  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            tick();
            n_tests++;
            if (actv() !== expv() || dut.q !== m_q || $countones(gnt) > 1) begin
                n_fail++;
                $display("FAIL random cyc %0d: got %b q %b want %b q %b", c, actv(), dut.q, expv(), m_q);
            end
        end
        req = '0; seed_load = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int c = 0; c < 4; c++) tick();
        req = 4'b1111;
        for (int c = 0; c < 3; c++) tick();
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (gnt !== 4'b0000 || rvalid !== 1'b0 || rdata !== 5'd0 || ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: gnt %b rv %b rdata %b ready %b want all zero", gnt, rvalid, rdata, ready);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 5; c++) tick();
        n_tests++;
        if (gnt !== 4'b0001 || actv() !== expv()) begin
            n_fail++;
            $display("FAIL reset_mid_restart: got %b want gnt 0001 vec %b", actv(), expv());
        end
        req = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_lockup();
        test_all_req();
        test_seed_warmup();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
